fifo_wptr_full: RTL

Write-domain control stage that sits directly upstream of the FIFO storage memory and drives its write address and write enable. It keeps the write pointer as a binary and Gray-coded (ADDR_SIZE+1)-bit counter and synchronizes the read-domain Gray pointer with two flops. From those it produces registered full, almost_full and fill-level outputs. The exported Gray write pointer is consumed by the read-domain empty logic.

---
 rtl/fifo_wptr_full.sv | 75 +++++++
 1 files changed

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - FIFO write-domain pointer, read-pointer sync, full/almost-full/level flags
module fifo_wptr_full #(
    parameter int ADDR_SIZE = 3,
    parameter int AF_MARGIN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_inc,
    input  logic [ADDR_SIZE:0]   r_ptr_gray,
    output logic                 w_en,
    output logic [ADDR_SIZE-1:0] w_addr,
    output logic [ADDR_SIZE:0]   w_ptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   w_level
);

    localparam int MEM_SIZE = 2 ** ADDR_SIZE;
    // Full when the write pointer leads the read pointer by exactly MEM_SIZE: in Gray
    // code that is the two MSBs inverted and the rest equal.
    localparam logic [ADDR_SIZE:0] FULL_MASK = (ADDR_SIZE + 1)'(3 << (ADDR_SIZE - 1));
    localparam logic [ADDR_SIZE:0] AF_LEVEL  = (ADDR_SIZE + 1)'(MEM_SIZE - AF_MARGIN);

    logic [ADDR_SIZE:0] r_w_bin;
    logic [ADDR_SIZE:0] r_w_gray;
    logic [ADDR_SIZE:0] r_rq1;
    logic [ADDR_SIZE:0] r_rq2;
    logic               r_full;
    logic               r_almost_full;
    logic [ADDR_SIZE:0] r_w_level;

    logic [ADDR_SIZE:0] w_b_next;
    logic [ADDR_SIZE:0] w_g_next;
    logic [ADDR_SIZE:0] w_r_bin;
    logic [ADDR_SIZE:0] w_level_next;

    assign w_en         = w_inc & ~r_full;
    assign w_b_next     = r_w_bin + {{ADDR_SIZE{1'b0}}, w_en};
    assign w_g_next     = w_b_next ^ (w_b_next >> 1);
    assign w_level_next = w_b_next - w_r_bin;

    always_comb begin
        w_r_bin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            w_r_bin[i] = ^(r_rq2 >> i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_bin       <= '0;
            r_w_gray      <= '0;
            r_rq1         <= '0;
            r_rq2         <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_w_level     <= '0;
        end else begin
            r_rq1         <= r_ptr_gray;
            r_rq2         <= r_rq1;
            r_w_bin       <= w_b_next;
            r_w_gray      <= w_g_next;
            r_full        <= (w_g_next == (r_rq2 ^ FULL_MASK));
            r_almost_full <= (w_level_next >= AF_LEVEL);
            r_w_level     <= w_level_next;
        end
    end

    assign w_addr      = r_w_bin[ADDR_SIZE-1:0];
    assign w_ptr_gray  = r_w_gray;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign w_level     = r_w_level;

endmodule
